imm_encoder: RTL

//  Inverse of the immediate decoder: packs a 32-bit signed/unsigned immediate into the

---
 rtl/imm_encoder_pkg.sv | 44 ++++
 rtl/imm_field_pack.sv | 44 ++++
 rtl/imm_encoder.sv | 92 +++++++++
 3 files changed

// File: rtl/imm_encoder_pkg.sv
// Shared immediate-format codes, error bit indices and the range/alignment check
// for the RISC-V immediate encoder.
package imm_encoder_pkg;

  localparam logic [2:0] IMM_I    = 3'd0;
  localparam logic [2:0] IMM_S    = 3'd1;
  localparam logic [2:0] IMM_B    = 3'd2;
  localparam logic [2:0] IMM_U    = 3'd3;
  localparam logic [2:0] IMM_J    = 3'd4;
  localparam logic [2:0] IMM_NONE = 3'd5;

  localparam int ERR_RANGE    = 0;
  localparam int ERR_MISALIGN = 1;
  localparam int ERR_BADSEL   = 2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [2:0]  sel;
    logic [2:0]  err;
  } s1_t;

  // An immediate fits iff its upper bits are a pure sign extension.
  function automatic logic [2:0] imm_check(input logic [31:0] imm, input logic [2:0] sel);
    logic [2:0] e;
    e = '0;
    case (sel)
      IMM_I, IMM_S: e[ERR_RANGE] = !((&imm[31:11]) || !(|imm[31:11]));
      IMM_B: begin
        e[ERR_RANGE]    = !((&imm[31:12]) || !(|imm[31:12]));
        e[ERR_MISALIGN] = imm[0];
      end
      IMM_U: e[ERR_MISALIGN] = |imm[11:0];
      IMM_J: begin
        e[ERR_RANGE]    = !((&imm[31:20]) || !(|imm[31:20]));
        e[ERR_MISALIGN] = imm[0];
      end
      IMM_NONE: e = '0;
      default:  e[ERR_BADSEL] = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/imm_field_pack.sv
// Combinational scatter of an immediate into the I/S/B/U/J fields of a template;
// any flagged error returns the template untouched.
module imm_field_pack
  import imm_encoder_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] imm,
  input  logic [2:0]  sel,
  input  logic [2:0]  chk_err,
  output logic [31:0] instr_o,
  output logic [2:0]  err_o
);

  logic [31:0] word;

  always_comb begin
    word = instr;
    case (sel)
      IMM_I: word[31:20] = imm[11:0];
      IMM_S: begin
        word[31:25] = imm[11:5];
        word[11:7]  = imm[4:0];
      end
      IMM_B: begin
        word[31]    = imm[12];
        word[7]     = imm[11];
        word[30:25] = imm[10:5];
        word[11:8]  = imm[4:1];
      end
      IMM_U: word[31:12] = imm[31:12];
      IMM_J: begin
        word[31]    = imm[20];
        word[19:12] = imm[19:12];
        word[20]    = imm[11];
        word[30:21] = imm[10:1];
      end
      default: word = instr;
    endcase
  end

  assign instr_o = (|chk_err) ? instr : word;
  assign err_o   = chk_err;

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready immediate encoder: stage1 captures request plus check flags,
// stage2 holds the merged instruction word; counts erroring results (saturating).
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_instr,
  input  logic [31:0]      s_imm,
  input  logic [2:0]       s_imm_sel,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_instr,
  output logic [2:0]       m_err,
  output logic [CNT_W-1:0] err_cnt
);

  logic [2:1]       vld_pipe_q, vld_pipe_d;
  s1_t              s1_q, s1_d;
  logic [31:0]      m_instr_q, m_instr_d;
  logic [2:0]       m_err_q, m_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             s2_free, s1_advance;
  logic [31:0]      pk_instr;
  logic [2:0]       pk_err;

  // Stage2 can take a new word when empty or being consumed this cycle.
  assign s2_free    = !vld_pipe_q[2] || m_ready;
  assign s1_advance = vld_pipe_q[1] && s2_free;
  assign s_ready    = !vld_pipe_q[1] || s1_advance;

  imm_field_pack u_pack (
    .instr   (s1_q.instr),
    .imm     (s1_q.imm),
    .sel     (s1_q.sel),
    .chk_err (s1_q.err),
    .instr_o (pk_instr),
    .err_o   (pk_err)
  );

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    s1_d       = s1_q;
    m_instr_d  = m_instr_q;
    m_err_d    = m_err_q;
    err_cnt_d  = err_cnt_q;
    if (s_ready) begin
      vld_pipe_d[1] = s_valid;
      if (s_valid) begin
        s1_d.instr = s_instr;
        s1_d.imm   = s_imm;
        s1_d.sel   = s_imm_sel;
        s1_d.err   = imm_check(s_imm, s_imm_sel);
      end
    end
    if (s2_free) begin
      vld_pipe_d[2] = vld_pipe_q[1];
      if (s1_advance) begin
        m_instr_d = pk_instr;
        m_err_d   = pk_err;
      end
    end
    if (vld_pipe_q[2] && m_ready && (|m_err_q) && !(&err_cnt_q))
      err_cnt_d = err_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      s1_q       <= '0;
      m_instr_q  <= '0;
      m_err_q    <= '0;
      err_cnt_q  <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      s1_q       <= s1_d;
      m_instr_q  <= m_instr_d;
      m_err_q    <= m_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign m_valid = vld_pipe_q[2];
  assign m_instr = m_instr_q;
  assign m_err   = m_err_q;
  assign err_cnt = err_cnt_q;

endmodule
